// File: rtl/hex_scan_driver_pkg.sv
// hex_scan_driver_pkg: segment code constants shared by the scan driver and its decoder
package hex_scan_driver_pkg;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_OFF = 7'b1111111;
  localparam seg_t SEG_HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
endpackage

// File: rtl/hex_scan_driver_hex_to_seg.sv
// hex_to_seg: nibble to active-low 7-segment pattern
module hex_to_seg
  import hex_scan_driver_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg_t       seg_o
);
  assign seg_o = SEG_HEX[nib_i];
endmodule

// File: rtl/hex_scan_driver.sv
// hex_scan_driver: multiplexed hex display with tear-free shadow/display double buffering
module hex_scan_driver
  import hex_scan_driver_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [4*DIGITS-1:0] data_i,
  input  logic                we_i,
  input  logic                en_i,
  output seg_t                seg_o,
  output logic [DIGITS-1:0]   an_o,
  output logic [4*DIGITS-1:0] latched_o,
  output logic                frame_o
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [4*DIGITS-1:0] shadow, disp;
  logic [DIGITS-1:0] lz;
  logic tc, last, blank;
  logic [3:0] nib;
  seg_t dec;
  assign tc = presc == PW'(REFRESH_DIV - 1);
  assign last = idx == IW'(DIGITS - 1);
  assign frame_o = tc && last;
  assign latched_o = shadow;
  assign nib = disp[4*idx +: 4];
  // lz[i]: nibbles i..DIGITS-1 of the display register are all zero
  always_comb begin
    lz = '0;
    lz[DIGITS-1] = disp[4*DIGITS-1 -: 4] == 4'd0;
    for (int i = DIGITS - 2; i >= 0; i--) lz[i] = lz[i+1] && disp[4*i +: 4] == 4'd0;
  end
  assign blank = BLANK_LZ && idx != '0 && lz[idx];
  hex_to_seg u_dec (.nib_i(nib), .seg_o(dec));
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc  <= '0;
      idx    <= '0;
      shadow <= '0;
      disp   <= '0;
      an_o   <= ~DIGITS'(1);
      seg_o  <= SEG_HEX[0];
    end else begin
      presc <= tc ? '0 : presc + 1'b1;
      if (tc) idx <= last ? '0 : idx + 1'b1;
      if (we_i) shadow <= data_i;
      if (frame_o) disp <= we_i ? data_i : shadow;
      an_o  <= en_i ? ~(DIGITS'(1) << idx) : '1;
      seg_o <= en_i && !blank ? dec : SEG_OFF;
    end
  end
endmodule
